// File: rtl/main_fsm_hs.sv
`default_nettype none
// ============================================================================
// main_fsm_hs : multi-cycle RV32I control FSM with req/ready memory handshake,
//               wait-state timeout to a sticky bus error, and retire pulse.
// Optional macro MAIN_FSM_TRAP_EN adds a trap output/state for unknown opcodes.
// Revision: 1.0
// ============================================================================
module main_fsm_hs #(
  parameter int SUBWORD_RMW = 1,
  parameter int TIMEOUT     = 16,
  parameter int TCNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       blt,
  input  logic       bge,
  input  logic       bltu,
  input  logic       bgeu,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] alu_op,
  output logic       mem_req,
  output logic       retire,
  output logic       bus_error
`ifdef MAIN_FSM_TRAP_EN
  ,
  output logic       trap
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [TCNT_W-1:0] TMO_VAL = TCNT_W'(TIMEOUT);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_READ,
    S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_JALR, S_UPDATE_PC, S_ERROR
`ifdef MAIN_FSM_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [TCNT_W-1:0] wait_cnt;
  logic              access;
  logic              timed_out;
  logic              taken;
  logic              unused_funct7;

  assign unused_funct7 = ^funct7;
  assign access    = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TMO_VAL) && !mem_ready;

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = blt;
      3'b101:  taken = bge;
      3'b110:  taken = bltu;
      3'b111:  taken = bgeu;
      default: taken = 1'b0;
    endcase
  end

  // The wait counter only ever measures the current stay in one access state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (access && !mem_ready)
        wait_cnt <= wait_cnt + TCNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = 2'b00;
    mem_req    = 1'b0;
    retire     = 1'b0;
    bus_error  = 1'b0;
`ifdef MAIN_FSM_TRAP_EN
    trap       = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_ERROR;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
          ALUSrcB  = 2'b10;
          RegWrite = 1'b1;
        end else begin
          ALUSrcB  = 2'b01;
        end
        case (opcode)
          OP_R:              state_next = S_EXEC_R;
          OP_I, OP_LUI:      state_next = S_EXEC_I;
          OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_AUIPC:          state_next = S_ALU_WB;
          default: begin
`ifdef MAIN_FSM_TRAP_EN
            state_next = S_TRAP;
`else
            retire     = 1'b1;
            state_next = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (state == S_EXEC_I) ? 2'b01 : 2'b00;
        alu_op     = 2'b10;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        if (opcode == OP_LOAD) begin
          state_next = S_MEM_READ;
        end else begin
          case (funct3)
            3'b000, 3'b001: state_next = (SUBWORD_RMW != 0) ? S_MEM_READ : S_MEM_WRITE;
            3'b010:         state_next = S_MEM_WRITE;
            default: begin
              retire     = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
      end
      S_MEM_READ, S_MEM_WRITE: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        AdrSrc  = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          if (state == S_MEM_WRITE) begin
            MemWrite   = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            // A store reaching MEM_READ is the read half of a read-modify-write.
            state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_WB;
          end
        end else if (timed_out) begin
          state_next = S_ERROR;
        end
      end
      S_MEM_WB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b01;
        PCWrite    = taken;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL, S_JALR: begin
        ALUSrcA    = (state == S_JAL) ? 2'b01 : 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        PCWrite    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ERROR: begin
        bus_error = 1'b1;
      end
`ifdef MAIN_FSM_TRAP_EN
      S_TRAP: begin
        trap = 1'b1;
      end
`endif
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // Reset overrides everything so an in-flight request drops immediately.
    if (!rst) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      alu_op    = 2'b00;
      mem_req   = 1'b0;
      retire    = 1'b0;
      bus_error = 1'b0;
`ifdef MAIN_FSM_TRAP_EN
      trap      = 1'b0;
`endif
    end
  end

endmodule
`default_nettype wire
